// File: rtl/audio_note_player.sv
// Note player: times each sequencer note, pulses counter_done, and synthesizes a square-wave tone.
// Optional AUDIO_NOTE_GAP_EN silences the last NOTE_CYCLES/8 cycles of every note.
module audio_note_player #(
    parameter int                 NOTE_CYCLES = 12_500_000,
    parameter logic signed [15:0] AMPLITUDE   = 16'sd8000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_note,
    input  logic [6:0]         note,
    output logic               counter_done,
    output logic               note_active,
    output logic               tone_level,
    output logic signed [15:0] sample
);

    localparam int DW = $clog2(NOTE_CYCLES);
    localparam logic [DW-1:0] LAST = DW'(NOTE_CYCLES - 1);
    localparam logic [DW-1:0] PRE  = DW'(NOTE_CYCLES - 2);
`ifdef AUDIO_NOTE_GAP_EN
    localparam logic [DW-1:0] GAP_START = DW'(NOTE_CYCLES - NOTE_CYCLES / 8);
`endif

    typedef enum logic {IDLE, PLAY} state_t;

    state_t      state_q, state_n;
    logic [DW-1:0] dur_q, dur_n;
    logic [17:0] phase_q, phase_n;
    logic [6:0]  note_q, note_n;
    logic        tone_q, tone_n;
    logic        done_n;
    logic        rest_n;
    logic        gap_n;
    logic        sound_n;
    logic [17:0] half_raw;
    logic [17:0] half;

    // Octave-3 half periods at 50 MHz; higher octaves shift right
    function automatic logic [17:0] base_half(input logic [3:0] p);
        logic [17:0] t;
        case (p)
            4'd0:    t = 18'd191113;
            4'd1:    t = 18'd180386;
            4'd2:    t = 18'd170262;
            4'd3:    t = 18'd160707;
            4'd4:    t = 18'd151686;
            4'd5:    t = 18'd143173;
            4'd6:    t = 18'd135135;
            4'd7:    t = 18'd127551;
            4'd8:    t = 18'd120395;
            4'd9:    t = 18'd113636;
            4'd10:   t = 18'd107258;
            4'd11:   t = 18'd101239;
            default: t = 18'd0;
        endcase
        return t;
    endfunction

    always_comb begin
        half_raw = base_half(note_q[3:0]) >> note_q[6:4];
        half     = (half_raw < 18'd2) ? 18'd2 : half_raw;
    end

    always_comb begin
        state_n = state_q;
        dur_n   = dur_q;
        phase_n = phase_q;
        note_n  = note_q;
        tone_n  = tone_q;
        done_n  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_note) begin
                    state_n = PLAY;
                    note_n  = note;
                    dur_n   = '0;
                    phase_n = '0;
                    tone_n  = 1'b1;
                end
            end
            PLAY: begin
                if (!enable_note) begin
                    state_n = IDLE;
                    dur_n   = '0;
                    phase_n = '0;
                    tone_n  = 1'b0;
                end else if (note != note_q) begin
                    note_n  = note;
                    dur_n   = '0;
                    phase_n = '0;
                    tone_n  = 1'b1;
                end else begin
                    done_n = (dur_q == PRE);
                    dur_n  = (dur_q == LAST) ? '0 : dur_q + 1'b1;
                    if (phase_q == half - 18'd1) begin
                        phase_n = '0;
                        tone_n  = ~tone_q;
                    end else begin
                        phase_n = phase_q + 18'd1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        rest_n = (note_n[3:0] >= 4'd12);
`ifdef AUDIO_NOTE_GAP_EN
        gap_n = (dur_n >= GAP_START);
`else
        gap_n = 1'b0;
`endif
        sound_n = (state_n == PLAY) && !rest_n && !gap_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            dur_q        <= '0;
            phase_q      <= '0;
            note_q       <= '0;
            tone_q       <= 1'b0;
            counter_done <= 1'b0;
            note_active  <= 1'b0;
            tone_level   <= 1'b0;
            sample       <= '0;
        end else begin
            state_q      <= state_n;
            dur_q        <= dur_n;
            phase_q      <= phase_n;
            note_q       <= note_n;
            tone_q       <= tone_n;
            counter_done <= done_n;
            note_active  <= (state_n == PLAY);
            tone_level   <= sound_n & tone_n;
            sample       <= sound_n ? (tone_n ? AMPLITUDE : -AMPLITUDE) : 16'sd0;
        end
    end

endmodule

// File: tb/tb_audio_note_player.sv
// Bench for audio_note_player: vector table of notes plus hand sequences,
// with a queue of expected counter_done cycles checked as pulses arrive.
module tb_audio_note_player;

    localparam int NC = 16;
    localparam logic signed [15:0] AMP = 16'sd8000;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable_note;
    logic [6:0]         note;
    logic               counter_done;
    logic               note_active;
    logic               tone_level;
    logic signed [15:0] sample;

    always #5 clk = ~clk;

    audio_note_player #(
        .NOTE_CYCLES(NC),
        .AMPLITUDE  (AMP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_note (enable_note),
        .note        (note),
        .counter_done(counter_done),
        .note_active (note_active),
        .tone_level  (tone_level),
        .sample      (sample)
    );

    typedef struct {
        logic [6:0] code;
        int         half;
        bit         rest;
    } vec_t;

    vec_t vecs[7];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int base = 0;
    bit tracking = 1'b0;
    int exp_q[$];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit in_gap();
`ifdef AUDIO_NOTE_GAP_EN
        return ((cyc - base) % NC) >= (NC - NC / 8);
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        if (tracking && ((cyc + 1 - base) % NC == NC - 1))
            exp_q.push_back(cyc + 1);
        @(posedge clk);
        cyc++;
        #1;
        while (exp_q.size() > 0 && exp_q[0] < cyc)
            check("done_missed_at", -1, exp_q.pop_front());
        if (counter_done === 1'b1) begin
            if (exp_q.size() == 0) check("done_unexpected", cyc, -1);
            else check("done_cycle", cyc, exp_q.pop_front());
        end
    endtask

    task automatic do_reset();
        enable_note = 1'b0;
        tracking = 1'b0;
        exp_q.delete();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic start_note(input logic [6:0] code);
        enable_note = 1'b1;
        note = code;
        base = cyc + 1;
        tracking = 1'b1;
        step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_done"}, counter_done, 0);
        check({tag, "_active"}, note_active, 0);
        check({tag, "_tone"}, tone_level, 0);
        check({tag, "_sample"}, sample, 0);
    endtask

    initial begin
        int bad, fall, rise, t, pulses;
        bit et;
        logic signed [31:0] es;

        vecs[0] = '{7'h50, 5972, 1'b0};
        vecs[1] = '{7'h54, 4740, 1'b0};
        vecs[2] = '{7'h7B, 790, 1'b0};
        vecs[3] = '{7'h60, 2986, 1'b0};
        vecs[4] = '{7'h48, 7524, 1'b0};
        vecs[5] = '{7'h1C, 0, 1'b1};
        vecs[6] = '{7'h0F, 0, 1'b1};

        reset = 1'b0;
        enable_note = 1'b0;
        note = 7'h00;
        #2 reset = 1'b1;
        #1;
        check_zero("reset");
        step();
        step();
        reset = 1'b0;
        step();
        check_zero("idle");

        foreach (vecs[i]) begin
            do_reset();
            start_note(vecs[i].code);
            check("start_active", note_active, 1);
            check("start_tone", tone_level, vecs[i].rest ? 0 : 1);
            check("start_sample", sample, vecs[i].rest ? 0 : 32'sd8000);
            bad = 0;
            if (vecs[i].rest) begin
                for (int k = 0; k < 3 * NC; k++) begin
                    step();
                    if (tone_level !== 1'b0 || sample !== 16'sd0) bad++;
                end
                check("rest_silent_bad", bad, 0);
            end else begin
                fall = -1;
                rise = -1;
                for (int k = 0; k < 2 * vecs[i].half + 3; k++) begin
                    step();
                    t = cyc - base;
                    et = ((t / vecs[i].half) % 2) == 0;
                    if (in_gap()) begin
                        if (tone_level !== 1'b0 || sample !== 16'sd0) bad++;
                    end else begin
                        es = et ? 32'sd8000 : -32'sd8000;
                        if (tone_level !== et || sample !== es) bad++;
                        if (fall < 0 && tone_level === 1'b0) fall = t;
                        if (fall >= 0 && rise < 0 && tone_level === 1'b1) rise = t;
                    end
                end
                check("half_fall", fall, vecs[i].half);
                check("half_rise", rise, 2 * vecs[i].half);
                check("wave_bad", bad, 0);
            end
            enable_note = 1'b0;
            tracking = 1'b0;
            step();
            check("stop_active", note_active, 0);
        end

        do_reset();
        start_note(7'h10);
        pulses = 0;
        for (int k = 0; k < 2 * NC - 1; k++) begin
            step();
            if (counter_done === 1'b1) pulses++;
        end
        check("pulse_count_2n", pulses, 2);

        do_reset();
        start_note(7'h10);
        repeat (4) step();
        enable_note = 1'b0;
        tracking = 1'b0;
        step();
        check("drop_active", note_active, 0);
        check("drop_sample", sample, 0);
        check("drop_tone", tone_level, 0);
        pulses = 0;
        for (int k = 0; k < 2 * NC; k++) begin
            step();
            if (counter_done === 1'b1) pulses++;
        end
        check("drop_no_pulse", pulses, 0);
        start_note(7'h10);
        pulses = 0;
        for (int k = 0; k < NC; k++) begin
            step();
            if (counter_done === 1'b1) pulses++;
        end
        check("reenable_pulse", pulses, 1);

        do_reset();
        start_note(7'h54);
        repeat (6) step();
        reset = 1'b1;
        tracking = 1'b0;
        exp_q.delete();
        #1;
        check_zero("async_reset");
        enable_note = 1'b0;
        step();
        step();
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 2 * NC; k++) begin
            step();
            if (counter_done === 1'b1) pulses++;
        end
        check("reset_no_pulse", pulses, 0);

        do_reset();
        start_note(7'h7B);
        repeat (NC - 1) step();
        check("edge_done_high", counter_done, 1);
        enable_note = 1'b0;
        tracking = 1'b0;
        step();
        check("edge_done_low", counter_done, 0);
        check("edge_idle", note_active, 0);

        do_reset();
        start_note(7'h54);
        repeat (4740) step();
        check("pre_change_tone", tone_level, in_gap() ? 0 : 0);
        note = 7'h7B;
        base = cyc + 1;
        step();
        check("change_tone", tone_level, 1);
        check("change_sample", sample, 32'sd8000);
        check("change_active", note_active, 1);
        fall = -1;
        for (int k = 0; k < 800; k++) begin
            step();
            if (fall < 0 && !in_gap() && tone_level === 1'b0) fall = cyc - base;
        end
        check("change_half", fall, 790);
        enable_note = 1'b0;
        tracking = 1'b0;
        step();

        do_reset();
        start_note(7'h7B);
        bad = 0;
        for (int k = 1; k < NC; k++) begin
            step();
`ifdef AUDIO_NOTE_GAP_EN
            es = (k >= NC - NC / 8) ? 32'sd0 : 32'sd8000;
`else
            es = 32'sd8000;
`endif
            if (sample !== es) bad++;
        end
        check("duration_shape_bad", bad, 0);
        enable_note = 1'b0;
        tracking = 1'b0;
        step();

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
